// File: rtl/morse_letter_tx.sv
// Morse transmitter for letters S-Z: plays a latched letter on one LED, one unit per tick.
// Optional MORSE_REPEAT_EN replays the letter forever with a GAP_UNITS-long dark gap.
module morse_letter_tx #(
  parameter int GAP_UNITS = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tick,
  input  logic       start,
  input  logic [2:0] letter,
  output logic       led,
  output logic       busy,
  output logic       done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
`ifdef MORSE_REPEAT_EN
  localparam logic [1:0] GAP  = 2'd2;
`endif

  if (GAP_UNITS < 1 || GAP_UNITS > 15) begin : g_bad_gap
    $error("GAP_UNITS must be in 1..15");
  end

  // Left-aligned unit patterns, first unit in bit 13.
  function automatic logic [13:0] pattern_of(input logic [2:0] code);
    case (code)
      3'd0:    pattern_of = {5'b10101, 9'd0};
      3'd1:    pattern_of = {3'b111, 11'd0};
      3'd2:    pattern_of = {7'b1010111, 7'd0};
      3'd3:    pattern_of = {9'b101010111, 5'd0};
      3'd4:    pattern_of = {9'b101110111, 5'd0};
      3'd5:    pattern_of = {11'b11101010111, 3'd0};
      3'd6:    pattern_of = {13'b1110101110111, 1'b0};
      3'd7:    pattern_of = {11'b11101110101, 3'd0};
      default: pattern_of = 14'd0;
    endcase
  endfunction

  function automatic logic [3:0] length_of(input logic [2:0] code);
    case (code)
      3'd0:    length_of = 4'd5;
      3'd1:    length_of = 4'd3;
      3'd2:    length_of = 4'd7;
      3'd3:    length_of = 4'd9;
      3'd4:    length_of = 4'd9;
      3'd5:    length_of = 4'd11;
      3'd6:    length_of = 4'd13;
      3'd7:    length_of = 4'd11;
      default: length_of = 4'd0;
    endcase
  endfunction

  logic [1:0]  state_r, state_s;
  logic [13:0] shift_r, shift_s;
  logic [3:0]  remaining_r, remaining_s;
  logic        last_r, last_s;
  logic        led_r, busy_r, done_r;
`ifdef MORSE_REPEAT_EN
  logic [3:0]  gap_r, gap_s;
  logic [2:0]  code_r, code_s;
`endif

  // Next-state logic: load on start, shift on tick, end-of-letter handling.
  always_comb begin
    state_s     = state_r;
    shift_s     = shift_r;
    remaining_s = remaining_r;
    last_s      = 1'b0;
`ifdef MORSE_REPEAT_EN
    gap_s       = gap_r;
    code_s      = code_r;
    if (start) begin
      code_s = letter;
    end else begin
      code_s = code_r;
    end
`endif
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s     = SEND;
          shift_s     = pattern_of(letter);
          remaining_s = length_of(letter);
        end else begin
          state_s = IDLE;
        end
      end
      SEND: begin
        if (tick && remaining_r > 4'd1) begin
          shift_s     = {shift_r[12:0], 1'b0};
          remaining_s = remaining_r - 4'd1;
        end else if (tick) begin
          last_s      = 1'b1;
          shift_s     = 14'd0;
          remaining_s = 4'd0;
`ifdef MORSE_REPEAT_EN
          state_s     = GAP;
          gap_s       = 4'(GAP_UNITS);
`else
          state_s     = IDLE;
`endif
        end else begin
          state_s = SEND;
        end
      end
`ifdef MORSE_REPEAT_EN
      // A code latched during this very cycle is honoured by the reload.
      GAP: begin
        if (tick && gap_r > 4'd1) begin
          gap_s = gap_r - 4'd1;
        end else if (tick) begin
          gap_s       = 4'd0;
          state_s     = SEND;
          shift_s     = pattern_of(code_s);
          remaining_s = length_of(code_s);
        end else begin
          state_s = GAP;
        end
      end
`endif
      default: state_s = IDLE;
    endcase
  end

  // State registers; outputs are registered from the current state, one cycle behind it.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r     <= IDLE;
      shift_r     <= 14'd0;
      remaining_r <= 4'd0;
      last_r      <= 1'b0;
      led_r       <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
`ifdef MORSE_REPEAT_EN
      gap_r       <= 4'd0;
      code_r      <= 3'd0;
`endif
    end else begin
      state_r     <= state_s;
      shift_r     <= shift_s;
      remaining_r <= remaining_s;
      last_r      <= last_s;
      led_r       <= (state_r == SEND) && shift_r[13];
      busy_r      <= (state_r != IDLE);
      done_r      <= last_r;
`ifdef MORSE_REPEAT_EN
      gap_r       <= gap_s;
      code_r      <= code_s;
`endif
    end
  end

  assign led  = led_r;
  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_morse_letter_tx.sv
// Directed self-checking bench for morse_letter_tx (default build; repeat-mode section under MORSE_REPEAT_EN).
module tb_morse_letter_tx;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic [2:0] letter = 3'd0;
  logic       led, busy, done;

  int checks = 0;
  int passed = 0;

  morse_letter_tx #(.GAP_UNITS(3)) dut (
    .clock (clock),
    .reset (reset),
    .tick  (tick),
    .start (start),
    .letter(letter),
    .led   (led),
    .busy  (busy),
    .done  (done)
  );

  always #5 clock = ~clock;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end else begin
      passed++;
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic tick_unit();
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
  endtask

  // Play one letter with a tick every 4 clocks; optionally poke start while busy.
  task automatic play(input logic [2:0] code, input logic [12:0] pat, input int len, input bit poke);
    letter = code;
    start  = 1'b1;
    step();
    start  = 1'b0;
    step();
    for (int i = 0; i < len; i++) begin
      check_value("unit_led", led, pat[len-1-i]);
      check_value("unit_busy", busy, 1'b1);
      check_value("unit_done", done, 1'b0);
      if (poke) begin
        start  = 1'b1;
        letter = ~code;
      end
      step();
      start  = 1'b0;
      letter = code;
      check_value("hold_led", led, pat[len-1-i]);
      step();
      tick_unit();
    end
    check_value("end_done", done, 1'b1);
    check_value("end_led", led, 1'b0);
    check_value("end_busy", busy, 1'b0);
    step();
    check_value("after_done", done, 1'b0);
    check_value("after_busy", busy, 1'b0);
  endtask

  initial begin
    // Reset held with start high and tick toggling.
    reset = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick = i[0];
      step();
      check_value("rst_led", led, 1'b0);
      check_value("rst_busy", busy, 1'b0);
      check_value("rst_done", done, 1'b0);
    end
    start = 1'b0;
    tick  = 1'b0;
    reset = 1'b1;
    step();

`ifndef MORSE_REPEAT_EN
    play(3'b000, 13'b10101, 5, 1'b0);
    play(3'b110, 13'b1110101110111, 13, 1'b1);

    // Reset in the middle of X.
    letter = 3'b101;
    start  = 1'b1;
    step();
    start  = 1'b0;
    step();
    for (int i = 0; i < 4; i++) tick_unit();
    check_value("x_mid_busy", busy, 1'b1);
    reset = 1'b0;
    step();
    check_value("xrst_led", led, 1'b0);
    check_value("xrst_busy", busy, 1'b0);
    check_value("xrst_done", done, 1'b0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_value("xrst_nodone", done, 1'b0);
      check_value("xrst_idle", busy, 1'b0);
    end
    play(3'b001, 13'b111, 3, 1'b0);

    // Start and tick in the same cycle: tick must not be consumed.
    letter = 3'b001;
    start  = 1'b1;
    tick   = 1'b1;
    step();
    start  = 1'b0;
    tick   = 1'b0;
    step();
    check_value("col_led", led, 1'b1);
    check_value("col_busy", busy, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      check_value("col_hold", led, 1'b1);
    end
    tick_unit();
    tick_unit();
    check_value("col_not_done", done, 1'b0);
    check_value("col_still_busy", busy, 1'b1);
    check_value("col_led3", led, 1'b1);
    tick_unit();
    check_value("col_done", done, 1'b1);
    check_value("col_idle", busy, 1'b0);
`else
    begin
      int led_exp [18] = '{1,1,1,0,0,0,1,1,1,0,0,0,1,0,1,0,1,0};
      int done_exp[18] = '{0,0,0,1,0,0,0,0,0,1,0,0,0,0,0,0,0,1};
      letter = 3'b001;
      start  = 1'b1;
      step();
      start  = 1'b0;
      step();
      for (int u = 0; u < 18; u++) begin
        check_value("rep_led", led, led_exp[u]);
        check_value("rep_done", done, done_exp[u]);
        check_value("rep_busy", busy, 1'b1);
        if (u == 10) begin
          letter = 3'b000;
          start  = 1'b1;
          step();
          start  = 1'b0;
        end
        tick_unit();
      end
    end
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, expected finished");
    $fatal(1);
  end

endmodule
